inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter XLEN, default 32, width of PC and instruction.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 redirect  in  1  branch/jump taken in ID; flush and refetch.
REQ-006 redirect_pc  in  XLEN  new fetch address; bits [1:0] treated as zero.
REQ-007 halt  in  1  terminate seen; stop issuing new requests.
REQ-008 imem_req  out  1  fetch request valid.
REQ-009 imem_addr  out  XLEN  fetch byte address, word aligned.
REQ-010 imem_gnt  in  1  request accepted this cycle.
REQ-011 imem_rvalid  in  1  response valid; arrives exactly 1 cycle after the granting cycle.
REQ-012 imem_rdata  in  XLEN  fetched instruction word.
REQ-013 out_valid  out  1  queue head valid toward IF/ID.
REQ-014 out_ready  in  1  IF/ID accepts head this cycle.
REQ-015 out_pc / out_pc_next / out_inst  out  XLEN each  head PC, PC+4, instruction.

Function
REQ-016 FSM states: S_IDLE (after reset, no request), S_FETCH (issue requests), S_HALT (no requests, drain only).
REQ-017 Transitions: S_IDLE->S_FETCH the first cycle after reset releases; S_FETCH->S_HALT when halt=1; S_HALT->S_FETCH only on redirect=1.
REQ-018 imem_req=1 only in S_FETCH while count+inflight < DEPTH and redirect=0.
REQ-019 imem_addr = fetch_pc; fetch_pc advances by 4 on each cycle with imem_req&imem_gnt; XLEN-bit wrap-around, no flag.
REQ-020 inflight (0 or 1) set on grant, cleared on rvalid; a grant and an rvalid in the same cycle leave inflight=1.
REQ-021 Response tagged with the PC captured at grant; pushed at tail on rvalid unless marked discard.
REQ-022 No bypass: a pushed word is visible at out_valid no earlier than the next cycle.
REQ-023 Pop when out_valid&out_ready; simultaneous push and pop leave count unchanged, both pointers advance.
REQ-024 Push never occurs when full (guaranteed by REQ-018); pop never occurs when empty.
REQ-025 When empty: out_valid=0, out_inst=32'h00000013 (NOP), out_pc=out_pc_next=0.
REQ-026 redirect=1 (highest priority): same cycle imem_req=0; next cycle count=0, pointers=0, fetch_pc=redirect_pc&~3, state=S_FETCH; an in-flight or same-cycle-granted response is discarded.
REQ-027 Pop and push requested in a redirect cycle are ignored; out_valid still reflects current head (consumer owns flushing of IF/ID).
REQ-028 halt and redirect together: redirect wins, state S_FETCH.
REQ-029 Pointers are log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

Reset
REQ-030 On rst=1 at posedge: state=S_IDLE, fetch_pc=0, count=0, pointers=0, inflight=0, discard=0.
REQ-031 During and one cycle after reset: imem_req=0, out_valid=0, out_inst=NOP; storage contents need not be cleared.
REQ-032 Reset mid-operation drops any in-flight response; an rvalid in the cycle after reset is ignored.

Structure
REQ-033 NOP encoding, ZERO/ONE and state encodings live in shared defines.v; DEPTH/XLEN stay parameters.
REQ-034 One sub-module, fetch_fifo_nbit (circular buffer, DEPTH x 2*XLEN, push/pop/full/empty/count); FSM and credit logic in inst_fetch_queue.

Verification
REQ-035 Reset, gnt=1 always, ready=1: imem_addr 0,4,8,... ; out_pc 0 appears 2 cycles after first grant with out_pc_next=4.
REQ-036 ready=0, gnt=1: exactly 4 grants (addr 0..12), then imem_req=0; count=4, out_pc held at 0.
REQ-037 Full queue, ready=1 for one cycle: one pop, next request addr 16 issued; count returns to 4.
REQ-038 redirect with redirect_pc=0x103 while response in flight: next cycle out_valid=0, imem_addr=0x100, stale rdata not pushed.
REQ-039 halt=1 after addr 8 granted: response for 8 pushed, no further requests; redirect to 0x40 resumes at 0x40.
REQ-040 fetch_pc=0xFFFFFFFC granted: next imem_addr=0x00000000, no error.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and FSM encoding for the instruction fetch queue.
package inst_fetch_queue_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Circular buffer holding {pc, instruction} pairs; flush empties it without touching storage.
module fetch_fifo_nbit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues single-outstanding imem requests under a credit limit
// and buffers tagged responses for IF/ID; redirect flushes and refetches.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_next,
    output logic [XLEN-1:0] out_inst
);
    localparam int unsigned AW = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   tag_pc_q, tag_pc_d;
    logic              inflight_q, inflight_d;
    logic              discard_q, discard_d;

    logic              grant, push, pop;
    logic              fifo_full, fifo_empty;
    logic [AW:0]       count;
    logic [AW+1:0]     credits;
    logic [2*XLEN-1:0] head;
    logic [XLEN-1:0]   head_pc;

    // The outstanding request reserves a slot so its response can never overflow the queue.
    assign credits   = {1'b0, count} + {{(AW+1){1'b0}}, inflight_q};
    assign imem_req  = (state_q == S_FETCH) && (credits < (AW+2)'(DEPTH)) && !redirect && !rst;
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;

    assign push      = imem_rvalid && inflight_q && !discard_q && !redirect && !rst && !fifo_full;
    assign out_valid = !fifo_empty && !rst;
    assign pop       = out_valid && out_ready && !redirect;

    assign head_pc     = head[2*XLEN-1:XLEN];
    assign out_pc      = out_valid ? head_pc : '0;
    assign out_pc_next = out_valid ? head_pc + XLEN'(4) : '0;
    assign out_inst    = out_valid ? head[XLEN-1:0] : XLEN'(NOP_INST);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        tag_pc_d   = tag_pc_q;
        inflight_d = grant || (inflight_q && !imem_rvalid);
        discard_d  = discard_q && !imem_rvalid;

        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (halt) state_d = S_HALT;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        if (grant) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            tag_pc_d   = fetch_pc_q;
        end

        // A response still due next cycle belongs to the old stream and must be dropped.
        if (redirect) begin
            state_d    = S_FETCH;
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            discard_d  = inflight_q && !imem_rvalid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= '0;
            tag_pc_q   <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            tag_pc_q   <= tag_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo_nbit #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({tag_pc_q, imem_rdata}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a queue-based reference model predicts requests
// and queue contents; a separate monitor checks the head whenever it is presented.
module tb_inst_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic        clk = 1'b0;
    logic        rst, redirect, halt, imem_gnt, imem_rvalid, out_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, out_pc, out_pc_next, out_inst;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    bit          m_started, m_halted, m_inflight, m_discard;
    logic [31:0] m_pc, m_tag;
    bit          mem_pending, post_rst;

    inst_fetch_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_pc_next (out_pc_next),
        .out_inst    (out_inst)
    );

    initial forever #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, check request side, then advance the model.
    task automatic step(input bit r, input bit rd, input logic [31:0] rpc,
                        input bit h, input bit g, input bit rdy);
        bit m_req;
        @(negedge clk);
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = h;
        imem_gnt    = g;
        out_ready   = rdy;
        imem_rvalid = mem_pending || post_rst;
        imem_rdata  = $urandom;
        #1;
        m_req = m_started && !m_halted && !r && !rd &&
                ((exp_q.size() + int'(m_inflight)) < int'(DEPTH));
        check32("imem_req", {31'd0, imem_req}, {31'd0, m_req});
        check32("imem_addr", imem_addr, m_pc);
        mem_pending = imem_req && g;
        post_rst    = r;
        #2;
        if (r) begin
            exp_q.delete();
            m_started  = 0;
            m_halted   = 0;
            m_inflight = 0;
            m_discard  = 0;
            m_pc       = '0;
        end else if (rd) begin
            exp_q.delete();
            m_pc       = rpc & ~32'h3;
            m_started  = 1;
            m_halted   = 0;
            m_discard  = m_inflight && !imem_rvalid;
            m_inflight = m_inflight && !imem_rvalid;
        end else begin
            if (imem_rvalid && m_inflight) begin
                if (!m_discard) exp_q.push_back('{pc: m_tag, inst: imem_rdata});
                m_inflight = 0;
                m_discard  = 0;
            end
            if (m_req && g) begin
                m_tag      = m_pc;
                m_pc       = m_pc + 32'd4;
                m_inflight = 1;
            end
            if (!m_started) m_started = 1;
            else if (h)     m_halted  = 1;
        end
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    initial begin
        entry_t e;
        bit     exp_valid;
        forever begin
            @(negedge clk);
            #2;
            exp_valid = (exp_q.size() != 0) && !rst;
            check32("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                e = exp_q[0];
                check32("out_pc", out_pc, e.pc);
                check32("out_pc_next", out_pc_next, e.pc + 32'd4);
                check32("out_inst", out_inst, e.inst);
                if (out_ready && !redirect) void'(exp_q.pop_front());
            end else begin
                check32("empty_pc", out_pc, 32'd0);
                check32("empty_pc_next", out_pc_next, 32'd0);
                check32("empty_inst", out_inst, 32'h0000_0013);
            end
        end
    end

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
        m_pc = '0; m_tag = '0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, 1);                 // streaming
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0);                 // fill, stall
        step(0, 0, 0, 0, 1, 1);                                              // single pop
        for (int i = 0; i < 4; i++)  step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++)  step(0, 0, 0, 0, 1, 1);
        step(0, 1, 32'h0000_0103, 0, 1, 1);                                  // redirect, response in flight
        for (int i = 0; i < 6; i++)  step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0, 1);                                              // halt
        for (int i = 0; i < 6; i++)  step(0, 0, 0, 0, 1, 1);
        step(0, 1, 32'h0000_0040, 1, 1, 1);                                  // halt+redirect
        for (int i = 0; i < 5; i++)  step(0, 0, 0, 0, 1, 1);
        step(0, 1, 32'hFFFF_FFF6, 0, 1, 1);                                  // address wrap
        for (int i = 0; i < 8; i++)  step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 1);                                              // mid-run reset
        for (int i = 0; i < 6; i++)  step(0, 0, 0, 0, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hF) : $urandom;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0), rpc,
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0));
        end

        @(negedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
